// File: rtl/mc_cpu_core.sv
// Parametrised multi-cycle CPU core (FETCH/EXEC/MEM/WB/HALT) with a req/ack memory port,
// illegal-opcode flagging, a retire pulse and a saturating retired-instruction counter.
module mc_cpu_core #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 11,
  parameter int unsigned       NUM_REGS = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              halted,
  output logic              retire,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired_count,
  output logic [ADDR_W-1:0] pc_dbg
);

  typedef enum logic [2:0] {StFetch, StExec, StMem, StWb, StHalt} state_e;

  localparam logic [3:0] OpNop  = 4'd0;
  localparam logic [3:0] OpLdi  = 4'd1;
  localparam logic [3:0] OpLd   = 4'd2;
  localparam logic [3:0] OpSt   = 4'd3;
  localparam logic [3:0] OpAlu  = 4'd4;
  localparam logic [3:0] OpJnz  = 4'd5;
  localparam logic [3:0] OpHalt = 4'd15;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_next_q;
  logic [31:0]       instr_q;
  logic [DATA_W-1:0] result_q, wdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              halt_ret_q;
  logic [DATA_W-1:0] regs_q [32];

  logic [3:0]        opc;
  logic [4:0]        rd_idx, a_idx, b_idx;
  logic [DATA_W-1:0] op_a, op_b, op_c, alu_res, shamt;
  logic [63:0]       rdata_ext;
  logic              reg_we, opc_illegal;
  logic              unused_ok;

  assign opc    = instr_q[31:28];
  assign rd_idx = instr_q[27:23];
  assign a_idx  = instr_q[22:18];
  assign b_idx  = instr_q[17:13];

  // Indices beyond the implemented register count read as zero.
  assign op_c = (32'(rd_idx) < NUM_REGS) ? regs_q[rd_idx] : '0;
  assign op_a = (32'(a_idx) < NUM_REGS) ? regs_q[a_idx] : '0;
  assign op_b = (32'(b_idx) < NUM_REGS) ? regs_q[b_idx] : '0;

  assign rdata_ext = 64'(mem_rdata);
  assign unused_ok = ^{rdata_ext[63:32], instr_q[12:3]};

  assign opc_illegal = !(opc inside {OpNop, OpLdi, OpLd, OpSt, OpAlu, OpJnz, OpHalt});

  always_comb begin
    shamt = op_b % DATA_W'(DATA_W);
    unique case (instr_q[2:0])
      3'd0:    alu_res = op_a + op_b;
      3'd1:    alu_res = op_a - op_b;
      3'd2:    alu_res = op_a & op_b;
      3'd3:    alu_res = op_a | op_b;
      3'd4:    alu_res = op_a ^ op_b;
      3'd5:    alu_res = op_a << shamt;
      3'd6:    alu_res = op_a >> shamt;
      default: alu_res = {{(DATA_W-1){1'b0}}, op_a < op_b};
    endcase
  end

  // Requests are gated by reset so an in-flight access drops the moment reset asserts.
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc_q;
    mem_wdata = wdata_q;
    unique case (state_q)
      StFetch: begin
        mem_req = rst;
        if (mem_ack) state_d = StExec;
      end
      StExec: begin
        case (opc)
          OpLd, OpSt: state_d = StMem;
          OpHalt:     state_d = StHalt;
          default:    state_d = StWb;
        endcase
      end
      StMem: begin
        mem_req  = rst;
        mem_we   = (opc == OpSt);
        mem_addr = addr_q;
        if (mem_ack) state_d = StWb;
      end
      StWb:    state_d = StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  assign halted        = (state_q == StHalt);
  assign retire        = (state_q == StWb) || (halted && !halt_ret_q);
  assign illegal       = (state_q == StWb) && opc_illegal;
  assign retired_count = cnt_q;
  assign pc_dbg        = pc_q;
  assign reg_we        = (state_q == StWb) && (opc inside {OpLdi, OpLd, OpAlu})
                         && (32'(rd_idx) < NUM_REGS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StFetch;
      pc_q       <= RESET_PC;
      cnt_q      <= '0;
      halt_ret_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StWb) pc_q <= pc_next_q;
      if (halted) halt_ret_q <= 1'b1;
      if (retire && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q   <= '0;
      result_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      pc_next_q <= RESET_PC;
    end else begin
      if (state_q == StFetch && mem_ack) instr_q <= rdata_ext[31:0];
      if (state_q == StExec) begin
        result_q  <= (opc == OpLdi) ? DATA_W'(instr_q[22:0]) : alu_res;
        addr_q    <= op_a[ADDR_W-1:0];
        wdata_q   <= op_c;
        pc_next_q <= (opc == OpJnz && op_c != '0) ? op_a[ADDR_W-1:0] : pc_q + ADDR_W'(1);
      end
      if (state_q == StMem && mem_ack && opc == OpLd) result_q <= mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (reg_we) begin
      regs_q[rd_idx] <= result_q;
    end
  end

endmodule

// File: tb/tb_mc_cpu_core.sv
// Self-checking bench for mc_cpu_core: memory model with random wait states, scoreboard of
// expected retires (pc, illegal) and expected stores.
module tb_mc_cpu_core;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 11;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr, pc_dbg;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          halted, retire, illegal;
  logic [CW-1:0] retired_count;

  mc_cpu_core #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(32), .RESET_PC(11'd0), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .halted(halted),
    .retire(retire), .illegal(illegal), .retired_count(retired_count), .pc_dbg(pc_dbg)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] prog [2048];
  logic [31:0] wmem [2048];
  bit          wr_valid [2048];
  logic [11:0] exp_ret [$];
  logic [42:0] exp_wr [$];
  logic [AW-1:0] pc_w;
  int unsigned wait_cnt, wait_tgt, max_wait;
  bit          stall, sb_on;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory slave: read data from stored writes first, otherwise from the program image.
  assign mem_ack   = mem_req && !(stall && mem_we) && (wait_cnt >= wait_tgt);
  assign mem_rdata = wr_valid[mem_addr] ? wmem[mem_addr] : prog[mem_addr];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= 0;
      wait_tgt <= 0;
    end else if (!mem_req) begin
      wait_cnt <= 0;
    end else if (mem_ack) begin
      wait_cnt <= 0;
      wait_tgt <= $urandom_range(max_wait, 0);
    end else begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  bit            hold;
  logic [AW-1:0] h_addr;
  logic          h_we;
  logic [DW-1:0] h_wdata;
  logic [63:0]   e;

  always @(negedge clk) begin
    if (!rst) begin
      hold = 1'b0;
      for (int i = 0; i < 2048; i++) wr_valid[i] = 1'b0;
    end else begin
      if (hold) begin
        check_eq("hold_addr", 64'(mem_addr), 64'(h_addr));
        check_eq("hold_we", 64'(mem_we), 64'(h_we));
        check_eq("hold_wdata", 64'(mem_wdata), 64'(h_wdata));
        check_eq("hold_req", 64'(mem_req), 64'd1);
      end
      hold    = mem_req && !mem_ack;
      h_addr  = mem_addr;
      h_we    = mem_we;
      h_wdata = mem_wdata;
      if (mem_req && mem_we && mem_ack) begin
        wmem[mem_addr]     = mem_wdata;
        wr_valid[mem_addr] = 1'b1;
        if (sb_on) begin
          e = 64'hDEAD_0000_0000;
          if (exp_wr.size() != 0) e = 64'(exp_wr.pop_front());
          check_eq("store", 64'({mem_addr, mem_wdata}), e);
        end
      end
      if (sb_on) begin
        check_eq("illegal_alone", 64'(illegal & ~retire), 64'd0);
        if (retire) begin
          e = 64'hDEAD;
          if (exp_ret.size() != 0) e = 64'(exp_ret.pop_front());
          check_eq("retire_pc_ill", 64'({illegal, pc_dbg}), e);
        end
      end
    end
  end

  function automatic logic [31:0] e_ldi(input int rd, input int imm);
    return {4'd1, 5'(rd), 23'(imm)};
  endfunction
  function automatic logic [31:0] e_ld(input int rd, input int ra);
    return {4'd2, 5'(rd), 5'(ra), 18'd0};
  endfunction
  function automatic logic [31:0] e_st(input int rs, input int ra);
    return {4'd3, 5'(rs), 5'(ra), 18'd0};
  endfunction
  function automatic logic [31:0] e_alu(input int rd, input int a, input int b, input int op);
    return {4'd4, 5'(rd), 5'(a), 5'(b), 10'd0, 3'(op)};
  endfunction
  function automatic logic [31:0] e_jnz(input int c, input int t);
    return {4'd5, 5'(c), 5'(t), 18'd0};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 2048; i++) prog[i] = 32'h0;
    exp_ret.delete();
    exp_wr.delete();
    pc_w = '0;
  endtask

  task automatic emit(input logic [31:0] w, input bit ill);
    prog[pc_w] = w;
    exp_ret.push_back({ill, pc_w});
    pc_w = pc_w + 11'd1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check_eq("rst_req", 64'(mem_req), 64'd0);
    check_eq("rst_halted", 64'(halted), 64'd0);
    check_eq("rst_retire", 64'({retire, illegal}), 64'd0);
    check_eq("rst_count", 64'(retired_count), 64'd0);
    check_eq("rst_pc", 64'(pc_dbg), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic finish_test(input string tag, input int exp_cnt, input int halt_pc);
    int i = 0;
    while (!halted && i < 3000) begin
      @(negedge clk);
      i++;
    end
    check_eq({tag, "_halted"}, 64'(halted), 64'd1);
    repeat (3) @(negedge clk);
    check_eq({tag, "_no_req"}, 64'(mem_req), 64'd0);
    check_eq({tag, "_count"}, 64'(retired_count), 64'(exp_cnt));
    check_eq({tag, "_halt_pc"}, 64'(pc_dbg), 64'(halt_pc));
    check_eq({tag, "_ret_left"}, 64'(exp_ret.size()), 64'd0);
    check_eq({tag, "_wr_left"}, 64'(exp_wr.size()), 64'd0);
  endtask

  task automatic load_t1();
    clear_prog();
    emit(e_ldi(1, 5), 1'b0);
    emit(e_ldi(2, 7), 1'b0);
    emit(e_alu(3, 1, 2, 0), 1'b0);
    emit(32'hF000_0000, 1'b0);
  endtask

  task automatic load_t3();
    clear_prog();
    emit(e_ldi(1, 5), 1'b0);
    emit(e_ldi(2, 7), 1'b0);
    emit(e_alu(3, 1, 2, 0), 1'b0);
    emit(e_ldi(4, 100), 1'b0);
    emit(e_st(3, 4), 1'b0);
    emit(e_ld(5, 4), 1'b0);
    emit(e_ldi(6, 101), 1'b0);
    emit(e_st(5, 6), 1'b0);
    emit(32'hF000_0000, 1'b0);
    exp_wr.push_back({11'd100, 32'd12});
    exp_wr.push_back({11'd101, 32'd12});
  endtask

  // r1=12 r2=5 r7=35 (shift 3); results stored at 200.. via r8 += r9.
  int          g_op  [8] = '{1, 6, 2, 3, 4, 5, 7, 7};
  int          g_a   [8] = '{2, 3, 1, 1, 1, 1, 2, 1};
  int          g_b   [8] = '{1, 7, 2, 2, 2, 7, 1, 2};
  int          g_rd  [8] = '{3, 4, 4, 4, 4, 4, 4, 4};
  logic [31:0] g_exp [8] = '{32'hFFFF_FFF9, 32'h1FFF_FFFF, 32'd4, 32'd13, 32'd9, 32'h60,
                             32'd1, 32'd0};

  task automatic load_alu();
    clear_prog();
    emit(e_ldi(1, 12), 1'b0);
    emit(e_ldi(2, 5), 1'b0);
    emit(e_ldi(7, 35), 1'b0);
    emit(e_ldi(8, 200), 1'b0);
    emit(e_ldi(9, 1), 1'b0);
    for (int g = 0; g < 8; g++) begin
      emit(e_alu(g_rd[g], g_a[g], g_b[g], g_op[g]), 1'b0);
      emit(e_st(g_rd[g], 8), 1'b0);
      emit(e_alu(8, 8, 9, 0), 1'b0);
      exp_wr.push_back({11'(200 + g), g_exp[g]});
    end
    emit(e_alu(1, 1, 1, 0), 1'b0);
    emit(e_st(1, 8), 1'b0);
    emit(32'h9080_0063, 1'b1);
    emit(e_st(1, 8), 1'b0);
    emit(32'hF000_0000, 1'b0);
    exp_wr.push_back({11'd208, 32'd24});
    exp_wr.push_back({11'd208, 32'd24});
  endtask

  task automatic load_t4();
    int order [9] = '{0, 1, 2, 3, 4, 5, 2047, 0, 8};
    clear_prog();
    prog[0]    = e_jnz(10, 11);
    prog[1]    = e_ldi(3, 3);
    prog[2]    = e_ldi(4, 23'h7FF);
    prog[3]    = e_ldi(11, 8);
    prog[4]    = e_jnz(0, 4);
    prog[5]    = e_jnz(3, 4);
    prog[6]    = 32'hF000_0000;
    prog[8]    = 32'hF000_0000;
    prog[2047] = e_ldi(10, 1);
    for (int i = 0; i < 9; i++) exp_ret.push_back({1'b0, 11'(order[i])});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int i;
    sb_on    = 1'b1;
    stall    = 1'b0;
    max_wait = 0;

    // Zero-wait latency: HALT reached after 11 edges, fourth retire counted at edge 12.
    load_t1();
    do_reset();
    repeat (10) @(posedge clk);
    #1 check_eq("t1_not_halted_10", 64'(halted), 64'd0);
    @(posedge clk);
    #1 check_eq("t1_halted_11", 64'(halted), 64'd1);
    check_eq("t1_count_11", 64'(retired_count), 64'd3);
    @(posedge clk);
    #1 check_eq("t1_count_12", 64'(retired_count), 64'd4);
    finish_test("t1", 4, 3);

    max_wait = 3;
    load_t1();
    do_reset();
    finish_test("t2", 4, 3);

    load_t3();
    do_reset();
    finish_test("t3", 9, 8);

    max_wait = 2;
    load_alu();
    do_reset();
    finish_test("alu", 34, 33);

    max_wait = 1;
    load_t4();
    do_reset();
    finish_test("t4", 9, 8);

    // Reset while the first store is stalled in MEM.
    max_wait = 0;
    load_t3();
    sb_on = 1'b0;
    stall = 1'b1;
    do_reset();
    i = 0;
    while (!(mem_req && mem_we) && i < 500) begin
      @(negedge clk);
      i++;
    end
    repeat (2) @(negedge clk);
    check_eq("t6_waiting", 64'({mem_req, mem_we}), 64'd3);
    #2 rst = 1'b0;
    #1 check_eq("t6_req_drop", 64'(mem_req), 64'd0);
    check_eq("t6_count", 64'(retired_count), 64'd0);
    check_eq("t6_pc", 64'(pc_dbg), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst   = 1'b1;
    stall = 1'b0;
    sb_on = 1'b1;
    #1 check_eq("t6_refetch", 64'({mem_req, mem_we, mem_addr}), 64'({2'b10, 11'd0}));
    finish_test("t6", 9, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
